// File: rtl/k423_lsu_pkg.sv
// rtl/k423_lsu_pkg.sv - shared op encoding, state enum and helpers for the MEM-stage LSU
package k423_lsu_pkg;

  localparam int LSU_OP_W = 5;
  localparam int OP_LOAD  = 4;
  localparam int OP_STORE = 3;
  localparam int OP_UNS   = 2;
  localparam int OP_SZ_HI = 1;
  localparam int OP_SZ_LO = 0;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int EXCP_MISALIGN = 1;
  localparam int EXCP_BUS_ERR  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RSP,
    ST_DRAIN
  } lsu_state_e;

  // Size 2'b11 is not a legal encoding; it is checked like a word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a_lo);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = a_lo[0];
      default: misaligned = (a_lo != 2'b00);
    endcase
  endfunction

  function automatic logic [1:0] excp_vec(input logic mis, input logic bus_err);
    excp_vec = '0;
    excp_vec[EXCP_MISALIGN] = mis;
    excp_vec[EXCP_BUS_ERR]  = bus_err;
  endfunction

endpackage

// File: rtl/k423_lsu_align.sv
// rtl/k423_lsu_align.sv - byte-lane strobes, store replication and load extraction/extension
module k423_lsu_align
  import k423_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      a_lo,
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ld_val
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {a_lo, 3'b000};

  always_comb begin
    wstrb  = 4'b1111;
    wdata  = rs2;
    ld_val = shifted;
    case (size)
      SZ_B: begin
        wstrb  = 4'b0001 << a_lo;
        wdata  = {(XLEN/8){rs2[7:0]}};
        ld_val = {{(XLEN-8){~uns & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        wstrb  = 4'b0011 << a_lo;
        wdata  = {(XLEN/16){rs2[15:0]}};
        ld_val = {{(XLEN-16){~uns & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/k423_mem_lsu.sv
// rtl/k423_mem_lsu.sv - MEM stage: pass-through writeback or one data-memory load/store per instruction
module k423_mem_lsu
  import k423_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                flush_i,
  input  logic                ex_vld_i,
  output logic                ex_rdy_o,
  input  logic [XLEN-1:0]     ex_alu_rd_i,
  input  logic [XLEN-1:0]     ex_rs2_i,
  input  logic [LSU_OP_W-1:0] ex_lsu_op_i,
  input  logic [4:0]          ex_rd_idx_i,
  input  logic                ex_rd_wen_i,
  output logic                dmem_req_vld_o,
  input  logic                dmem_req_rdy_i,
  output logic [ADDR_W-1:0]   dmem_req_addr_o,
  output logic                dmem_req_we_o,
  output logic [3:0]          dmem_req_wstrb_o,
  output logic [XLEN-1:0]     dmem_req_wdata_o,
  input  logic                dmem_rsp_vld_i,
  input  logic [XLEN-1:0]     dmem_rsp_rdata_i,
  input  logic                dmem_rsp_err_i,
  output logic                wb_vld_o,
  output logic [4:0]          wb_rd_idx_o,
  output logic                wb_rd_wen_o,
  output logic [XLEN-1:0]     wb_rd_o,
  output logic [1:0]          wb_excp_o
);

  lsu_state_e      state;
  logic [1:0]      a_lo_q, size_q;
  logic            uns_q, load_q, rd_wen_q;
  logic [4:0]      rd_idx_q;

  logic            accept, ex_load, ex_store, ex_mis;
  logic [1:0]      al_a_lo, al_size;
  logic            al_uns;
  logic [3:0]      al_wstrb;
  logic [XLEN-1:0] al_wdata, al_ld_val;

  // Gated by reset so the handshake reads 0 while the stage is held in reset.
  assign ex_rdy_o = (state == ST_IDLE) & rst_n_i;
  assign accept   = ex_vld_i & ex_rdy_o & ~flush_i;
  assign ex_load  = ex_lsu_op_i[OP_LOAD];
  assign ex_store = ex_lsu_op_i[OP_STORE];
  assign ex_mis   = misaligned(ex_lsu_op_i[OP_SZ_HI:OP_SZ_LO], ex_alu_rd_i[1:0]);

  // Store lanes come from the incoming op; load extraction uses the latched op.
  always_comb begin
    al_a_lo = a_lo_q;
    al_size = size_q;
    al_uns  = uns_q;
    if (state == ST_IDLE) begin
      al_a_lo = ex_alu_rd_i[1:0];
      al_size = ex_lsu_op_i[OP_SZ_HI:OP_SZ_LO];
      al_uns  = ex_lsu_op_i[OP_UNS];
    end
  end

  k423_lsu_align #(.XLEN(XLEN)) u_align (
    .a_lo   (al_a_lo),
    .size   (al_size),
    .uns    (al_uns),
    .rs2    (ex_rs2_i),
    .rdata  (dmem_rsp_rdata_i),
    .wstrb  (al_wstrb),
    .wdata  (al_wdata),
    .ld_val (al_ld_val)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state            <= ST_IDLE;
      a_lo_q           <= '0;
      size_q           <= '0;
      uns_q            <= 1'b0;
      load_q           <= 1'b0;
      rd_wen_q         <= 1'b0;
      rd_idx_q         <= '0;
      dmem_req_vld_o   <= 1'b0;
      dmem_req_addr_o  <= '0;
      dmem_req_we_o    <= 1'b0;
      dmem_req_wstrb_o <= '0;
      dmem_req_wdata_o <= '0;
      wb_vld_o         <= 1'b0;
      wb_rd_idx_o      <= '0;
      wb_rd_wen_o      <= 1'b0;
      wb_rd_o          <= '0;
      wb_excp_o        <= '0;
    end else begin
      wb_vld_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!ex_load && !ex_store) begin
              wb_vld_o    <= 1'b1;
              wb_rd_idx_o <= ex_rd_idx_i;
              wb_rd_wen_o <= ex_rd_wen_i;
              wb_rd_o     <= ex_alu_rd_i;
              wb_excp_o   <= excp_vec(1'b0, 1'b0);
            end else if (ex_mis) begin
              wb_vld_o    <= 1'b1;
              wb_rd_idx_o <= ex_rd_idx_i;
              wb_rd_wen_o <= 1'b0;
              wb_excp_o   <= excp_vec(1'b1, 1'b0);
            end else begin
              a_lo_q           <= ex_alu_rd_i[1:0];
              size_q           <= ex_lsu_op_i[OP_SZ_HI:OP_SZ_LO];
              uns_q            <= ex_lsu_op_i[OP_UNS];
              load_q           <= ex_load;
              rd_wen_q         <= ex_rd_wen_i;
              rd_idx_q         <= ex_rd_idx_i;
              dmem_req_vld_o   <= 1'b1;
              dmem_req_addr_o  <= {ex_alu_rd_i[ADDR_W-1:2], 2'b00};
              dmem_req_we_o    <= ex_store & ~ex_load;
              dmem_req_wstrb_o <= ex_store ? al_wstrb : 4'b0000;
              dmem_req_wdata_o <= ex_store ? al_wdata : '0;
              state            <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dmem_req_rdy_i) begin
            dmem_req_vld_o <= 1'b0;
            state          <= flush_i ? ST_DRAIN : ST_RSP;
          end else if (flush_i) begin
            dmem_req_vld_o <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        ST_RSP: begin
          // A response coinciding with the flush is the one a drain would wait for.
          if (dmem_rsp_vld_i) begin
            state <= ST_IDLE;
            if (!flush_i) begin
              wb_vld_o    <= 1'b1;
              wb_rd_idx_o <= rd_idx_q;
              wb_rd_wen_o <= rd_wen_q & load_q & ~dmem_rsp_err_i;
              wb_excp_o   <= excp_vec(1'b0, dmem_rsp_err_i);
              if (load_q) wb_rd_o <= al_ld_val;
            end
          end else if (flush_i) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (dmem_rsp_vld_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/k423_mem_lsu.md
Name: k423_mem_lsu

Overview:
- MEM stage directly downstream of the EX ALU.
- Consumes the ALU result as either a pass-through writeback value or a load/store effective address.
- Runs a data-memory request/response transaction, aligns and extends load data, and presents one writeback beat to the WB stage.
- Stalls EX through a valid/ready handshake while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath width (matches CORE_XLEN).
- ADDR_W, 32, data-memory address width (matches CORE_ADDR_W).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  kill the in-flight instruction (trap/redirect)
- ex_vld_i  in  1  EX presents an instruction
- ex_rdy_o  out  1  LSU can accept
- ex_alu_rd_i  in  XLEN  ALU result / effective address
- ex_rs2_i  in  XLEN  store data
- ex_lsu_op_i  in  LSU_OP_W(5)  {load, store, unsigned, size[1:0]}
- ex_rd_idx_i  in  5  destination register
- ex_rd_wen_i  in  1  destination write enable
- dmem_req_vld_o  out  1  request valid
- dmem_req_rdy_i  in  1  request accepted
- dmem_req_addr_o  out  ADDR_W  word-aligned address, bits[1:0]=0
- dmem_req_we_o  out  1  store
- dmem_req_wstrb_o  out  4  byte strobes
- dmem_req_wdata_o  out  XLEN  lane-shifted store data
- dmem_rsp_vld_i  in  1  response valid, one per accepted request
- dmem_rsp_rdata_i  in  XLEN  load data word
- dmem_rsp_err_i  in  1  bus error
- wb_vld_o  out  1  one-cycle writeback beat
- wb_rd_idx_o  out  5  destination register
- wb_rd_wen_o  out  1  register write enable
- wb_rd_o  out  XLEN  writeback data
- wb_excp_o  out  2  {misalign, bus_err}

Behaviour:
- Reset: all outputs 0, state IDLE, ex_rdy_o=1 after reset release. Clock and reset are clk_i / rst_n_i: one clock, asynchronous active-low reset.
- Reset mid-transaction: the FSM returns to IDLE immediately. The memory side is also reset, so there is no drain.
- FSM states: IDLE, REQ, RSP, DRAIN.
- ex_rdy_o = (state==IDLE). Accept = ex_vld_i & ex_rdy_o & ~flush_i.
- Non-memory op (load=store=0): wb_vld_o=1 the cycle after accept, with wb_rd_o=ex_alu_rd_i. State stays IDLE, giving throughput of 1 per cycle.
- Misalignment check on accept: half with addr[0]=1, or word with addr[1:0]!=0. No bus request is issued. wb_vld_o=1 next cycle with wb_excp_o[1]=1 and wb_rd_wen_o=0.
- Aligned memory op: latch address, op, rd, and shifted data; go to REQ. dmem_req_vld_o=1 from the next cycle.
- In REQ, request fields are held stable until dmem_req_rdy_i. On handshake, go to RSP.
- Store strobes: byte 4'b0001<<a[1:0]; half 4'b0011<<a[1:0]; word 4'b1111. wdata is rs2 replicated across lanes.
- In RSP: on dmem_rsp_vld_i, go to IDLE. wb_vld_o=1 the next cycle.
  - Load: select the byte/half lane by addr[1:0], then sign-extend, or zero-extend if unsigned.
  - Store: wb_rd_wen_o=0.
  - dmem_rsp_err_i: set wb_excp_o[0] and force wb_rd_wen_o=0.
- Minimum latency: accept→req 1 cycle; rsp→wb 1 cycle.
- A response arriving in the same cycle as request acceptance is illegal. The bus guarantees at least 1 cycle between them.
- flush_i handling:
  - In IDLE/REQ, the instruction is dropped and returns to IDLE. A REQ that is never handshaked is not issued. If dmem_req_rdy_i and flush_i occur in the same cycle, the request has been accepted, so go to DRAIN.
  - In RSP: go to DRAIN.
  - In DRAIN: swallow exactly one response, produce no wb_vld_o, then return to IDLE.
  - flush_i has priority over a same-cycle accept.
- No back-pressure from WB: wb_vld_o is a single-cycle pulse. Outputs are registered, and wb_rd_o holds its value when wb_vld_o=0.

Decomposition:
- Shared package k423_lsu_pkg holds:
  - LSU_OP_W and the op bit indices.
  - Size encodings: B=2'b00, H=2'b01, W=2'b10.
  - The state enum lsu_state_e.
  - The excp bit indices.
- One sub-module, k423_lsu_align, is purely combinational. It takes addr[1:0], size, unsigned, and rdata/rs2, and produces wstrb, wdata, and the extended load value.

Test Plan:
- ADD pass-through: ex_alu_rd_i=0x1234, rd=5, back-to-back 3 ops → wb_vld_o each following cycle, wb_rd_o=0x1234, no dmem_req_vld_o.
- LB at 0x1003, rdata=0x80FF_FF7F → wstrb unused; wb_rd_o=0xFFFFFF80. LBU gives 0x00000080.
- SH at 0x2002, rs2=0x0000ABCD, req_rdy low 3 cycles → addr/strobe/data held stable: addr=0x2000, wstrb=4'b1100, wdata=0xABCDABCD; ex_rdy_o=0 until after response; wb_rd_wen_o=0.
- LW at 0x3001 → no request; wb_excp_o=2'b10 next cycle; wb_rd_wen_o=0.
- LW accepted by bus, then flush_i in RSP; response arrives 2 cycles later with 0xDEAD → no wb_vld_o. A following ADD is accepted only after the drain.
- Bus error on LW 0x4000 → wb_excp_o=2'b01, wb_rd_wen_o=0. Assert rst_n_i low while in REQ → all outputs 0 asynchronously.
